lpixm_cmd_sequencer: RTL



---
 rtl/lpixm_cmd_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lpixm_cmd_sequencer.sv
`timescale 1ns/1ps
// lpixm_cmd_sequencer
// Turns a single-beat command (direction, start address, word count) into a
// run of LPI Q requests with incrementing word addresses. Write words come
// from the ws stream in lock-step with Q beats. Read words leave on the rs
// stream straight from the Y channel. Requests in flight are capped at
// MAX_OUTSTANDING. Each command ends with a one-cycle done pulse and a sticky
// error flag.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/ready, cmd_write,   command handshake and fields
//   cmd_addr, cmd_len
//   ws_valid/ready, ws_data       write-data input stream
//   rs_valid/ready, rs_data       read-data output stream
//   qvalid/qready, qdata          LPI request {wr, addr, wdata, wstrb}
//   yvalid/yready, ydata          LPI response {err, rdata}
//   busy, done, err               status
//   stat_cycles                   busy-cycle counter, present only when
//                                 LPIXM_CMD_SEQUENCER_STAT_EN is defined
module lpixm_cmd_sequencer #(
    parameter int BW_ADDR         = 32,
    parameter int BW_DATA         = 32,
    parameter int BW_LEN          = 16,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BW_STRB        = BW_DATA / 8,
    localparam int BW_QDATA       = 1 + BW_ADDR + BW_DATA + BW_STRB,
    localparam int BW_YDATA       = 1 + BW_DATA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [BW_ADDR-1:0]  cmd_addr,
    input  logic [BW_LEN-1:0]   cmd_len,
    input  logic                ws_valid,
    output logic                ws_ready,
    input  logic [BW_DATA-1:0]  ws_data,
    output logic                rs_valid,
    input  logic                rs_ready,
    output logic [BW_DATA-1:0]  rs_data,
    output logic                qvalid,
    input  logic                qready,
    output logic [BW_QDATA-1:0] qdata,
    input  logic                yvalid,
    output logic                yready,
    input  logic [BW_YDATA-1:0] ydata,
    output logic                busy,
    output logic                done,
`ifdef LPIXM_CMD_SEQUENCER_STAT_EN
    output logic [31:0]         stat_cycles,
`endif
    output logic                err
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]      MAX_OS    = OW'(MAX_OUTSTANDING);
    localparam logic [BW_ADDR-1:0] ADDR_MASK = BW_ADDR'(BW_STRB - 1);
    localparam logic [BW_ADDR-1:0] ADDR_INC  = BW_ADDR'(BW_STRB);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [OW-1:0]        outstanding_r, outstanding_s;
    logic                 write_r;
    logic [BW_ADDR-1:0]   addr_r;
    logic [BW_LEN-1:0]    remaining_r;
    logic                 err_r;

    logic                 accept_s;
    logic                 active_s;
    logic                 qvalid_s;
    logic                 yready_s;
    logic                 q_hs_s;
    logic                 y_hs_s;
    logic [BW_DATA-1:0]   wdata_s;
    logic [BW_STRB-1:0]   wstrb_s;

    // Handshake decode and outstanding-count arithmetic; kept apart from the
    // FSM block so the DRAIN exit can look at the post-handshake count.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && cmd_valid;
        active_s = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
        qvalid_s = (state_r == ST_ISSUE) && (outstanding_r < MAX_OS) && (!write_r || ws_valid);
        if (active_s && !write_r) begin
            yready_s = rs_ready;
        end else begin
            yready_s = 1'b1;
        end
        q_hs_s = qvalid_s && qready;
        // Responses outside ISSUE/DRAIN are stale and never touch the count.
        y_hs_s = active_s && yvalid && yready_s && (outstanding_r != {OW{1'b0}});
        if (q_hs_s && !y_hs_s) begin
            outstanding_s = outstanding_r + OW'(1);
        end else if (!q_hs_s && y_hs_s) begin
            outstanding_s = outstanding_r - OW'(1);
        end else begin
            outstanding_s = outstanding_r;
        end
        if (write_r) begin
            wdata_s = ws_data;
            wstrb_s = {BW_STRB{1'b1}};
        end else begin
            wdata_s = {BW_DATA{1'b0}};
            wstrb_s = {BW_STRB{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and channel outputs.
    always_comb begin
        state_s   = state_r;
        cmd_ready = 1'b0;
        qvalid    = 1'b0;
        qdata     = {BW_QDATA{1'b0}};
        ws_ready  = 1'b0;
        rs_valid  = 1'b0;
        rs_data   = ydata[BW_DATA-1:0];
        yready    = yready_s;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_s = (cmd_len != {BW_LEN{1'b0}}) ? ST_ISSUE : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                qvalid   = qvalid_s;
                qdata    = {write_r, addr_r, wdata_s, wstrb_s};
                ws_ready = write_r && q_hs_s;
                rs_valid = !write_r && yvalid;
                if (q_hs_s && (remaining_r == BW_LEN'(1))) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                rs_valid = !write_r && yvalid;
                if (outstanding_s == {OW{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Command latch, address/length walk, outstanding count and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r       <= 1'b0;
            addr_r        <= {BW_ADDR{1'b0}};
            remaining_r   <= {BW_LEN{1'b0}};
            outstanding_r <= {OW{1'b0}};
            err_r         <= 1'b0;
        end else if (accept_s) begin
            write_r       <= cmd_write;
            addr_r        <= cmd_addr & ~ADDR_MASK;
            remaining_r   <= cmd_len;
            outstanding_r <= {OW{1'b0}};
            err_r         <= 1'b0;
        end else begin
            if (q_hs_s) begin
                addr_r      <= addr_r + ADDR_INC;
                remaining_r <= remaining_r - BW_LEN'(1);
            end
            outstanding_r <= outstanding_s;
            if (y_hs_s) begin
                err_r <= err_r | ydata[BW_DATA];
            end
        end
    end

    assign err = err_r;

`ifdef LPIXM_CMD_SEQUENCER_STAT_EN
    logic [31:0] stat_cycles_r;

    // Busy-cycle counter: cleared on accept, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cycles_r <= 32'd0;
        end else if (accept_s) begin
            stat_cycles_r <= 32'd0;
        end else if ((state_r != ST_IDLE) && (stat_cycles_r != 32'hFFFF_FFFF)) begin
            stat_cycles_r <= stat_cycles_r + 32'd1;
        end
    end

    assign stat_cycles = stat_cycles_r;
`else
    // Statistics counter not built.
`endif

endmodule
